// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer responder on the CPU bus.
// Four word registers (CTRL, PRESET, COUNT, STATUS) and a registered IRQ.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h00007F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] pr_addr,
    input  logic [3:0]  pr_be,
    input  logic [31:0] pr_wd,
    input  logic        pr_we,
    output logic [31:0] pr_rd,
    output logic        dev_hit,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  ctrl;
    logic [3:0]  ctrl_nx;
    logic [31:0] preset;
    logic [31:0] preset_nx;
    logic [31:0] count;
    logic [31:0] count_nx;
    logic        pending;
    logic        pend_nx;
    logic        irq_nx;

    logic [1:0]  offset;
    logic        wr_hit;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        en;
    logic        auto_reload;
    logic        cnt_done;
    logic        hw_set;
    logic        hw_clr;
    logic        hw_en_clr;

    assign offset      = pr_addr[3:2];
    assign dev_hit     = (pr_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_hit      = pr_we & dev_hit;
    assign ctrl_wr     = wr_hit & (offset == OFF_CTRL) & pr_be[0];
    assign preset_wr   = wr_hit & (offset == OFF_PRESET);
    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign cnt_done    = (count <= 32'd1);

    // Countdown sequencing: next state, next count and pending set/clear requests.
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        hw_set    = 1'b0;
        hw_clr    = 1'b0;
        hw_en_clr = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                count_nx = preset;
                state_nx = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_nx = S_IDLE;
                end else if (cnt_done) begin
                    count_nx = 32'd0;
                    state_nx = S_INT;
                    hw_set   = 1'b1;
                end else begin
                    count_nx = count - 32'd1;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    state_nx = S_LOAD;
                    hw_clr   = 1'b1;
                end else begin
                    state_nx  = S_IDLE;
                    hw_en_clr = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Register-file updates; a bus CTRL write overrides the hardware EN clear
    // and its pending clear beats a simultaneous hardware set.
    always_comb begin
        ctrl_nx   = ctrl;
        preset_nx = preset;
        pend_nx   = pending;
        if (hw_en_clr) begin
            ctrl_nx[0] = 1'b0;
        end
        if (ctrl_wr) begin
            ctrl_nx = pr_wd[3:0];
        end
        if (preset_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (pr_be[b]) begin
                    preset_nx[b*8 +: 8] = pr_wd[b*8 +: 8];
                end
            end
        end
        if (hw_set) begin
            pend_nx = 1'b1;
        end
        if (hw_clr) begin
            pend_nx = 1'b0;
        end
        if (ctrl_wr) begin
            pend_nx = 1'b0;
        end
        irq_nx = pend_nx & ctrl_nx[3];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Programmer-visible registers and pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= 4'd0;
            preset  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            ctrl    <= ctrl_nx;
            preset  <= preset_nx;
            count   <= count_nx;
            pending <= pend_nx;
        end
    end

    // Interrupt output, registered from next-state pending and mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_nx;
        end
    end

    // Combinational read mux; zero outside the window.
    always_comb begin
        pr_rd = 32'd0;
        if (dev_hit) begin
            unique case (offset)
                OFF_CTRL:   pr_rd = {28'd0, ctrl};
                OFF_PRESET: pr_rd = preset;
                OFF_COUNT:  pr_rd = count;
                OFF_STATUS: pr_rd = {31'd0, pending};
                default:    pr_rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expectations; a monitor pops and compares on each probe.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] pr_addr = '0;
    logic [3:0]  pr_be = '0;
    logic [31:0] pr_wd = '0;
    logic        pr_we = 1'b0;
    logic [31:0] pr_rd;
    logic        dev_hit;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [1:0]  kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    event probe;

    localparam logic [31:0] A_CTRL = 32'h7F00;
    localparam logic [31:0] A_PRE  = 32'h7F04;
    localparam logic [31:0] A_CNT  = 32'h7F08;
    localparam logic [31:0] A_STAT = 32'h7F0C;
    localparam logic [31:0] A_OUT  = 32'h7F10;

    logic [31:0] os_cnt [9] = '{0, 5, 4, 3, 2, 1, 0, 0, 0};
    logic        os_irq [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [31:0] ar_cnt [15] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0};
    logic        ar_irq [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    bus_timer #(.BASE_ADDR(32'h00007F00)) dut (
        .clk     (clk),
        .reset   (reset),
        .pr_addr (pr_addr),
        .pr_be   (pr_be),
        .pr_wd   (pr_wd),
        .pr_we   (pr_we),
        .pr_rd   (pr_rd),
        .dev_hit (dev_hit),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Monitor: drain all pending expectations against the live DUT outputs.
    initial begin
        forever begin
            @(probe);
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.kind)
                    2'd0:    act = pr_rd;
                    2'd1:    act = {31'd0, irq};
                    default: act = {31'd0, dev_hit};
                endcase
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        pr_addr = a[31:2];
        pr_wd   = d;
        pr_be   = be;
        pr_we   = 1'b1;
        tick();
        pr_we   = 1'b0;
        pr_be   = 4'd0;
    endtask

    task automatic ex_rd(input string nm, input logic [31:0] a,
                         input logic [31:0] v);
        pr_addr = a[31:2];
        #1;
        sb.push_back('{nm, 2'd0, v});
        ->probe;
        #1;
    endtask

    task automatic ex_irq(input string nm, input logic v);
        sb.push_back('{nm, 2'd1, {31'd0, v}});
        ->probe;
        #1;
    endtask

    task automatic ex_hit(input string nm, input logic [31:0] a,
                          input logic v);
        pr_addr = a[31:2];
        #1;
        sb.push_back('{nm, 2'd2, {31'd0, v}});
        ->probe;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset values.
        #2;
        ex_irq("rst_irq", 1'b0);
        ex_rd("rst_ctrl", A_CTRL, 32'h0);
        ex_rd("rst_pre", A_PRE, 32'h0);
        tick();
        ex_rd("rst_cnt", A_CNT, 32'h0);
        ex_rd("rst_stat", A_STAT, 32'h0);
        ex_hit("rst_hit", A_CTRL, 1'b1);
        reset = 1'b0;

        // Byte enables and read-only COUNT.
        wr(A_PRE, 32'h11223344, 4'hF);
        ex_rd("pre_full", A_PRE, 32'h11223344);
        wr(A_PRE, 32'hAABBCCDD, 4'b0101);
        ex_rd("pre_be", A_PRE, 32'h11BB33DD);
        wr(A_CNT, 32'h00001234, 4'hF);
        ex_rd("cnt_ro", A_CNT, 32'h0);
        wr(A_CTRL, 32'h0000000F, 4'b1110);
        ex_rd("ctrl_be0", A_CTRL, 32'h0);

        // Out-of-window decode.
        wr(A_OUT, 32'hFFFFFFFF, 4'hF);
        ex_hit("hit_out", A_OUT, 1'b0);
        ex_rd("rd_out", A_OUT, 32'h0);
        ex_rd("pre_kept", A_PRE, 32'h11BB33DD);
        tick();
        ex_rd("ctrl_kept", A_CTRL, 32'h0);
        ex_hit("hit_low", 32'h7EF0, 1'b0);

        // One-shot, PRESET=5, IM=1.
        do_reset();
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 0; k < 9; k++) begin
            tick();
            ex_rd($sformatf("os_cnt_e%0d", k + 1), A_CNT, os_cnt[k]);
            ex_irq($sformatf("os_irq_e%0d", k + 1), os_irq[k]);
        end
        ex_rd("os_ctrl", A_CTRL, 32'h8);
        ex_rd("os_stat", A_STAT, 32'h1);
        tick();
        ex_irq("os_irq_hold", 1'b1);
        wr(A_CTRL, 32'h8, 4'hF);
        ex_irq("os_irq_clr", 1'b0);
        ex_rd("os_stat_clr", A_STAT, 32'h0);

        // Auto-reload, PRESET=3: pulse every 5 cycles.
        do_reset();
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        for (int k = 0; k < 15; k++) begin
            tick();
            ex_rd($sformatf("ar_cnt_e%0d", k + 1), A_CNT, ar_cnt[k]);
            ex_irq($sformatf("ar_irq_e%0d", k + 1), ar_irq[k]);
        end

        // Disable mid-count, then re-enable.
        do_reset();
        wr(A_PRE, 32'd10, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        ex_rd("dis_cnt6", A_CNT, 32'd6);
        wr(A_CTRL, 32'h8, 4'hF);
        ex_rd("dis_cnt5", A_CNT, 32'd5);
        for (int k = 0; k < 10; k++) begin
            tick();
            ex_rd($sformatf("dis_hold_%0d", k), A_CNT, 32'd5);
            ex_irq($sformatf("dis_irq_%0d", k), 1'b0);
        end
        wr(A_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        ex_rd("dis_reload", A_CNT, 32'd10);

        // CTRL write during INT beats the EN clear; PRESET=0 acts as 1.
        do_reset();
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        ex_rd("p0_cnt", A_CNT, 32'd0);
        ex_irq("p0_irq_e2", 1'b0);
        tick();
        ex_irq("p0_irq_e3", 1'b1);
        wr(A_CTRL, 32'h9, 4'hF);
        ex_rd("sim_ctrl", A_CTRL, 32'h9);
        ex_rd("sim_stat", A_STAT, 32'h0);
        ex_irq("sim_irq", 1'b0);
        tick();
        tick();
        ex_irq("sim_irq_e6", 1'b0);
        tick();
        ex_irq("sim_irq_e7", 1'b1);

        // Asynchronous reset mid-count.
        do_reset();
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        tick();
        ex_rd("mid_cnt", A_CNT, 32'd4);
        reset = 1'b1;
        #1;
        ex_irq("mr_irq", 1'b0);
        ex_rd("mr_cnt", A_CNT, 32'h0);
        ex_rd("mr_ctrl", A_CTRL, 32'h0);
        tick();
        ex_rd("mr_stat", A_STAT, 32'h0);
        ex_rd("mr_pre", A_PRE, 32'h0);
        ex_hit("mr_hit", A_PRE, 1'b1);
        reset = 1'b0;
        tick();

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Responder-side memory-mapped countdown timer on the processor bus driven by the CPU core (word address [31:2], byte enables, write data, write enable, read data, HWInt[7:2]).
- Decodes its own 16-byte window, accepts register writes and returns read data.
- Counts down a preset value and raises an interrupt intended for HWInt[2].

Parameters:
- BASE_ADDR, 32'h00007F00, byte base of the 16-byte register window; bits [3:0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pr_addr  in  30  CPU word address [31:2]
- pr_be  in  4  byte enables for the write
- pr_wd  in  32  write data
- pr_we  in  1  write strobe; one write per cycle when high
- pr_rd  out  32  read data, combinational from pr_addr
- dev_hit  out  1  high when pr_addr[31:4] == BASE_ADDR[31:4]; used by the bridge read mux
- irq  out  1  interrupt request, registered

Behaviour:
- Write: takes effect at the clk edge where pr_we & dev_hit.
- Register map, offset = pr_addr[3:2]:
  - 0 CTRL: rw, bits [3:0] = {IM, MODE[1:0], EN}; write uses pr_be[0] only; bits [31:4] read 0.
  - 1 PRESET: rw, 32-bit; each byte written only if its pr_be bit is set.
  - 2 COUNT: read-only; writes ignored.
  - 3 STATUS: read-only; bit0 = pending, rest 0; writes ignored.
- pr_rd = register selected by pr_addr[3:2] when dev_hit, else 32'h0.
- MODE 00 = one-shot. MODE 01 = auto-reload. MODE 1x behaves as 00.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT <= 1, COUNT <= 0 and go to INT. Else COUNT <= COUNT-1.
  - INT: pending <= 1. In one-shot, EN <= 0 and go to IDLE. In auto-reload, go to LOAD.
- Pending clear:
  - One-shot: pending holds until any CTRL write, which clears it.
  - Auto-reload: pending clears on the edge leaving INT, giving a one-cycle pulse.
- irq <= pending & IM, registered from the next-state value so irq rises on the same edge pending sets.
- Latency: EN write at edge 0 → LOAD after edge 1 → COUNT=N after edge 2 → INT and irq high after edge N+2, for N >= 1.
- PRESET=0 behaves as PRESET=1.
- Auto-reload period = N+2 cycles.
- A PRESET write during CNT does not change COUNT; it is used at the next LOAD.
- Simultaneous events:
  - A CTRL write in the same cycle as the INT hardware clear of EN wins, so the written EN is kept.
  - That CTRL write still clears pending, and the write-clear beats the set.
- CTRL write with EN=0 during LOAD or CNT: FSM enters IDLE on the following edge; COUNT freezes.
- Reset (any time, including mid-count):
  - CTRL=0, PRESET=0, COUNT=0, pending=0, irq=0, state=IDLE.
  - pr_rd and dev_hit stay combinational and are unaffected.
- Writes with dev_hit=0 change nothing.
- Reads have no side effects.

Test Plan:
- Reset then read: assert reset mid-count with PRESET=5 → immediately irq=0; reads of COUNT, CTRL and STATUS return 0.
- One-shot:
  - Write PRESET=5 at 0x7F04, then CTRL=4'b1001 at 0x7F00 (edge 0).
  - Required: COUNT reads 5 after edge 2, 4 after edge 3; irq high after edge 7; CTRL reads 4'b1000; irq stays high.
  - A CTRL write of 4'b1000 drops irq after the next edge.
- Auto-reload: PRESET=3, CTRL=4'b1011 → irq is a one-cycle pulse every 5 cycles (first after edge 5); COUNT sequence 3,2,1,0,0 repeats.
- Byte enables:
  - PRESET=32'h11223344, then write 32'hAABBCCDD with pr_be=4'b0101 → PRESET reads 32'h11BB33DD.
  - A write to COUNT is ignored.
- Decode:
  - Write to 0x7F10 → no register changes; dev_hit=0; pr_rd=0.
  - Read 0x7F0C during one-shot pending → 32'h1.
- Disable mid-count: PRESET=10, enable, write EN=0 when COUNT=6 → COUNT holds 5 or 6 (value at the freeze edge); irq never asserts; re-enabling reloads 10.
